acc_stack_unit: RTL and testbench

Parametrised next-generation SAP accumulator. It loads from the shared bus, with an optional zero-extended lower load. It also performs in-place add, subtract and shift against the bus and produces registered status flags. A DEPTH-entry save/restore stack lets the controller push and pop the accumulator for subroutine/interrupt context. It sits between the bus and the ALU/controller, replacing the plain accumulator.

---
 rtl/acc_stack_unit_if.sv | 45 ++++
 rtl/acc_stack_unit.sv | 120 ++++++++++++
 tb/tb_acc_stack_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_stack_unit_if.sv
// Bus-side bundle of the stacked accumulator: command strobes and data bus in,
// accumulator value, flags and stack status out.
interface acc_stack_unit_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    // Strobes are level commands sampled on every rising clk edge; there is no
    // back-pressure, so a command asserted for one cycle executes exactly once.
    logic             acc_write;
    logic             acc_lower_write;
    logic             acc_add;
    logic             acc_sub;
    logic             acc_shl;
    logic             acc_shr;
    logic             acc_push;
    logic             acc_pop;
    logic             err_clr;
    logic [WIDTH-1:0] bus;

    logic [WIDTH-1:0] aout;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic [CW-1:0]    stk_count;
    logic             stk_full;
    logic             stk_empty;
    logic             stk_err;

    modport master (
        output acc_write, acc_lower_write, acc_add, acc_sub, acc_shl, acc_shr,
               acc_push, acc_pop, err_clr, bus,
        input  aout, flag_z, flag_n, flag_c, flag_v,
               stk_count, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  acc_write, acc_lower_write, acc_add, acc_sub, acc_shl, acc_shr,
               acc_push, acc_pop, err_clr, bus,
        output aout, flag_z, flag_n, flag_c, flag_v,
               stk_count, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/acc_stack_unit.sv
// SAP accumulator with add/sub/shift, registered flags and a DEPTH-entry
// save/restore stack for subroutine and interrupt context.
module acc_stack_unit #(
    parameter int WIDTH = 16,
    parameter int LOW_W = 8,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    acc_stack_unit_if.slave io
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - LOW_W);

    logic [WIDTH-1:0] aout_q, aout_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic [CW-1:0]    count_q;
    logic             err_q;

    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [CW-1:0]    count_m1;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             full;
    logic             empty;
    logic             push_req, pop_req;
    logic             do_push, do_pop;
    logic             err_set;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count_m1 = count_q - CW'(1);
    assign wr_idx   = count_q[AW-1:0];
    assign rd_idx   = count_m1[AW-1:0];

    // A simultaneous push and pop is a controller conflict: neither is honoured.
    assign push_req = io.acc_push & ~io.acc_pop;
    assign pop_req  = io.acc_pop & ~io.acc_push;
    assign do_push  = push_req & ~full;
    assign do_pop   = pop_req & ~empty;
    assign err_set  = (io.acc_push & io.acc_pop) | (push_req & full) | (pop_req & empty);

    assign sum  = {1'b0, aout_q} + {1'b0, io.bus};
    assign diff = {1'b0, aout_q} - {1'b0, io.bus};

    always_comb begin
        aout_d = aout_q;
        c_d    = c_q;
        v_d    = v_q;
        if (do_pop) begin
            aout_d = stack_mem[rd_idx];
        end else if (io.acc_write) begin
            aout_d = io.bus;
        end else if (io.acc_lower_write) begin
            aout_d = io.bus & LOW_MASK;
        end else if (io.acc_add) begin
            aout_d = sum[WIDTH-1:0];
            c_d    = sum[WIDTH];
            v_d    = (aout_q[WIDTH-1] == io.bus[WIDTH-1]) && (sum[WIDTH-1] != aout_q[WIDTH-1]);
        end else if (io.acc_sub) begin
            // Zero-extended subtraction leaves the borrow in the top bit.
            aout_d = diff[WIDTH-1:0];
            c_d    = diff[WIDTH];
            v_d    = (aout_q[WIDTH-1] != io.bus[WIDTH-1]) && (diff[WIDTH-1] != aout_q[WIDTH-1]);
        end else if (io.acc_shl) begin
            aout_d = {aout_q[WIDTH-2:0], 1'b0};
            c_d    = aout_q[WIDTH-1];
            v_d    = 1'b0;
        end else if (io.acc_shr) begin
            aout_d = {1'b0, aout_q[WIDTH-1:1]};
            c_d    = aout_q[0];
            v_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aout_q  <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            aout_q <= aout_d;
            c_q    <= c_d;
            v_q    <= v_d;
            if (do_push) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop) begin
                count_q <= count_m1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (io.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // Stack contents need no reset; the count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[wr_idx] <= aout_q;
        end
    end

    assign io.aout      = aout_q;
    assign io.flag_z    = (aout_q == '0);
    assign io.flag_n    = aout_q[WIDTH-1];
    assign io.flag_c    = c_q;
    assign io.flag_v    = v_q;
    assign io.stk_count = count_q;
    assign io.stk_full  = full;
    assign io.stk_empty = empty;
    assign io.stk_err   = err_q;
endmodule

// File: tb/tb_acc_stack_unit.sv
// Bench for acc_stack_unit: directed scenarios plus random command mixes, all
// checked against an arithmetic model with a queue-based stack.
module tb_acc_stack_unit;
    localparam int W     = 16;
    localparam int LOW_W = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    // op bit positions
    localparam int OP_WR  = 0;
    localparam int OP_LO  = 1;
    localparam int OP_ADD = 2;
    localparam int OP_SUB = 3;
    localparam int OP_SHL = 4;
    localparam int OP_SHR = 5;
    localparam int OP_PSH = 6;
    localparam int OP_POP = 7;
    localparam int OP_CLR = 8;

    logic clk;
    logic rst_n;

    acc_stack_unit_if #(.WIDTH(W), .DEPTH(DEPTH)) io ();

    acc_stack_unit #(.WIDTH(W), .LOW_W(LOW_W), .DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];      // saved accumulator values, top at back
    longint       m_acc;
    bit           m_c, m_v, m_err;
    int           n_cmp, n_err;

    function automatic longint to_signed(input longint x);
        return (x >= (64'sd1 << (W - 1))) ? x - (64'sd1 << W) : x;
    endfunction

    function automatic bit ovf(input longint s);
        return (s > ((64'sd1 << (W - 1)) - 1)) || (s < -(64'sd1 << (W - 1)));
    endfunction

    task automatic model_reset();
        m_acc = 0;
        m_c   = 0;
        m_v   = 0;
        m_err = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [8:0] ops, input logic [W-1:0] b);
        longint mod = 64'sd1 << W;
        longint bv  = longint'(b);
        bit     popped = 0;
        bit     new_err = 0;
        longint nxt = m_acc;
        if (ops[OP_PSH] && ops[OP_POP]) begin
            new_err = 1;
        end else if (ops[OP_PSH]) begin
            if (exp_q.size() == DEPTH) new_err = 1;
            else exp_q.push_back(W'(m_acc));
        end else if (ops[OP_POP]) begin
            if (exp_q.size() == 0) new_err = 1;
            else begin
                nxt    = longint'(exp_q.pop_back());
                popped = 1;
            end
        end
        if (!popped) begin
            if (ops[OP_WR]) nxt = bv;
            else if (ops[OP_LO]) nxt = bv % (64'sd1 << LOW_W);
            else if (ops[OP_ADD]) begin
                nxt = (m_acc + bv) % mod;
                m_c = (m_acc + bv) >= mod;
                m_v = ovf(to_signed(m_acc) + to_signed(bv));
            end else if (ops[OP_SUB]) begin
                nxt = (m_acc - bv + mod) % mod;
                m_c = m_acc < bv;
                m_v = ovf(to_signed(m_acc) - to_signed(bv));
            end else if (ops[OP_SHL]) begin
                nxt = (m_acc * 2) % mod;
                m_c = m_acc >= (mod / 2);
                m_v = 0;
            end else if (ops[OP_SHR]) begin
                nxt = m_acc / 2;
                m_c = m_acc % 2;
                m_v = 0;
            end
        end
        m_acc = nxt;
        if (new_err) m_err = 1;
        else if (ops[OP_CLR]) m_err = 0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".aout"},  32'(io.aout),      32'(m_acc));
        check({tag, ".z"},     32'(io.flag_z),    32'(m_acc == 0));
        check({tag, ".n"},     32'(io.flag_n),    32'(m_acc >= (64'sd1 << (W - 1))));
        check({tag, ".c"},     32'(io.flag_c),    32'(m_c));
        check({tag, ".v"},     32'(io.flag_v),    32'(m_v));
        check({tag, ".cnt"},   32'(io.stk_count), 32'(exp_q.size()));
        check({tag, ".full"},  32'(io.stk_full),  32'(exp_q.size() == DEPTH));
        check({tag, ".empty"}, 32'(io.stk_empty), 32'(exp_q.size() == 0));
        check({tag, ".err"},   32'(io.stk_err),   32'(m_err));
    endtask

    // ---------------- driver ----------------
    task automatic drive_idle();
        io.acc_write       = 1'b0;
        io.acc_lower_write = 1'b0;
        io.acc_add         = 1'b0;
        io.acc_sub         = 1'b0;
        io.acc_shl         = 1'b0;
        io.acc_shr         = 1'b0;
        io.acc_push        = 1'b0;
        io.acc_pop         = 1'b0;
        io.err_clr         = 1'b0;
        io.bus             = '0;
    endtask

    task automatic apply(input string tag, input logic [8:0] ops, input logic [W-1:0] b);
        @(negedge clk);
        io.acc_write       = ops[OP_WR];
        io.acc_lower_write = ops[OP_LO];
        io.acc_add         = ops[OP_ADD];
        io.acc_sub         = ops[OP_SUB];
        io.acc_shl         = ops[OP_SHL];
        io.acc_shr         = ops[OP_SHR];
        io.acc_push        = ops[OP_PSH];
        io.acc_pop         = ops[OP_POP];
        io.err_clr         = ops[OP_CLR];
        io.bus             = b;
        model_step(ops, b);
        @(posedge clk);
        #1;
        drive_idle();
        check_all(tag);
    endtask

    function automatic logic [8:0] op(input int bitpos);
        logic [8:0] r = '0;
        r[bitpos] = 1'b1;
        return r;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [8:0]   ops;
        logic [W-1:0] b;
        n_cmp = 0;
        n_err = 0;
        drive_idle();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("reset_init");

        // reset while holding a non-zero value
        apply("wr_1234", op(OP_WR), 16'h1234);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_all("reset_hold");
        check("reset_hold.aout_const", 32'(io.aout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("wr_abcd", op(OP_WR), 16'hABCD);
        check("wr_abcd.n_const", 32'(io.flag_n), 32'h1);
        apply("lo_abcd", op(OP_LO), 16'hABCD);
        check("lo_abcd.aout_const", 32'(io.aout), 32'h00CD);

        // add flags
        apply("wr_7fff", op(OP_WR), 16'h7FFF);
        apply("add_ovf", op(OP_ADD), 16'h0001);
        check("add_ovf.aout_const", 32'(io.aout), 32'h8000);
        check("add_ovf.v_const", 32'(io.flag_v), 32'h1);
        apply("wr_ffff", op(OP_WR), 16'hFFFF);
        apply("add_carry", op(OP_ADD), 16'h0001);
        check("add_carry.c_const", 32'(io.flag_c), 32'h1);
        apply("wr_8000", op(OP_WR), 16'h8000);
        apply("add_negovf", op(OP_ADD), 16'h8000);

        // sub and shifts
        apply("wr_0", op(OP_WR), 16'h0000);
        apply("sub_borrow", op(OP_SUB), 16'h0001);
        check("sub_borrow.aout_const", 32'(io.aout), 32'hFFFF);
        apply("wr_8000b", op(OP_WR), 16'h8000);
        apply("sub_ovf", op(OP_SUB), 16'h0001);
        apply("wr_8001", op(OP_WR), 16'h8001);
        apply("shl", op(OP_SHL), 16'h0);
        check("shl.aout_const", 32'(io.aout), 32'h0002);
        apply("shr", op(OP_SHR), 16'h0);
        check("shr.c_const", 32'(io.flag_c), 32'h0);

        // fill and drain the stack
        for (int i = 1; i <= DEPTH; i++) begin
            apply("fill_wr", op(OP_WR), 16'(i * 16'h0011));
            apply("fill_push", op(OP_PSH), 16'h0);
        end
        check("fill.full_const", 32'(io.stk_full), 32'h1);
        apply("push_full", op(OP_PSH) | op(OP_ADD), 16'h0100);
        check("push_full.err_const", 32'(io.stk_err), 32'h1);
        for (int i = DEPTH; i >= 1; i--) begin
            apply("drain_pop", op(OP_POP), 16'h0);
            check("drain_pop.aout_const", 32'(io.aout), 32'(i * 16'h0011));
        end
        apply("pop_empty", op(OP_POP), 16'h0);
        check("pop_empty.aout_const", 32'(io.aout), 32'h0011);
        apply("err_clr", op(OP_CLR), 16'h0);
        apply("pop_empty_clr", op(OP_POP) | op(OP_CLR), 16'h0);
        apply("err_clr2", op(OP_CLR), 16'h0);

        // concurrency
        apply("wr_5", op(OP_WR), 16'h0005);
        apply("push_add", op(OP_PSH) | op(OP_ADD), 16'h0003);
        check("push_add.aout_const", 32'(io.aout), 32'h0008);
        apply("pop_wr", op(OP_POP) | op(OP_WR), 16'h9999);
        check("pop_wr.aout_const", 32'(io.aout), 32'h0005);
        apply("push_pop", op(OP_PSH) | op(OP_POP) | op(OP_SHL), 16'h0);
        apply("err_clr3", op(OP_CLR), 16'h0);

        // async reset between edges with three entries stacked
        for (int i = 0; i < 3; i++) apply("pre_rst_push", op(OP_PSH) | op(OP_ADD), 16'h0101);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        apply("pop_after_rst", op(OP_POP), 16'h0);
        check("pop_after_rst.err_const", 32'(io.stk_err), 32'h1);

        // random command mixes
        for (int n = 0; n < 600; n++) begin
            ops = '0;
            for (int k = OP_WR; k <= OP_SHR; k++) ops[k] = ($urandom_range(0, 4) == 0);
            ops[OP_PSH] = ($urandom_range(0, 2) == 0);
            ops[OP_POP] = ($urandom_range(0, 2) == 0);
            ops[OP_CLR] = ($urandom_range(0, 6) == 0);
            case ($urandom_range(0, 5))
                0: b = 16'h0000;
                1: b = 16'hFFFF;
                2: b = 16'h7FFF;
                3: b = 16'h8000;
                default: b = W'($urandom);
            endcase
            apply("rand", ops, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
